debug_dump_scheduler: RTL



---
 rtl/debug_dump_scheduler.sv | 187 ++++++++++++++++++
 1 files changed

// File: rtl/debug_dump_scheduler.sv
// Serialises the pipeline-latch debug snapshot onto the UART TX as framed bytes.
// Each enabled frame is sent as a header byte followed by its payload, MSB first.
module debug_dump_scheduler #(
    parameter int NB_DATA    = 8,
    parameter int NB_IF_ID   = 96,
    parameter int NB_ID_EX   = 160,
    parameter int NB_EX_MEM  = 32,
    parameter int NB_MEM_WB  = 64,
    parameter int NB_CONTROL = 16,
    parameter logic [NB_DATA-1:0] HDR_BASE = 8'hA0
) (
    input  logic                  clk,
    input  logic                  i_rst_n,
    input  logic                  i_dump_start,
    input  logic                  i_abort,
    input  logic [4:0]            i_frame_mask,
    input  logic [NB_IF_ID-1:0]   i_data_IF_ID,
    input  logic [NB_ID_EX-1:0]   i_data_ID_EX,
    input  logic [NB_EX_MEM-1:0]  i_data_EX_MEM,
    input  logic [NB_MEM_WB-1:0]  i_data_MEM_WB,
    input  logic [NB_CONTROL-1:0] i_data_CONTROL,
    input  logic                  i_txDone,
    output logic                  o_tx_start,
    output logic [NB_DATA-1:0]    o_data,
    output logic                  o_busy,
    output logic [2:0]            o_frame_idx,
    output logic                  o_dump_done,
    output logic                  o_aborted
);

    localparam int NB_A   = (NB_IF_ID > NB_ID_EX) ? NB_IF_ID : NB_ID_EX;
    localparam int NB_B   = (NB_EX_MEM > NB_MEM_WB) ? NB_EX_MEM : NB_MEM_WB;
    localparam int NB_C   = (NB_A > NB_B) ? NB_A : NB_B;
    localparam int NB_MAX = (NB_C > NB_CONTROL) ? NB_C : NB_CONTROL;
    localparam int CNT_W  = $clog2(NB_MAX / NB_DATA + 1);

    typedef enum logic [2:0] {
        IDLE,
        SELECT,
        SEND,
        WAIT,
        DONE
    } state_t;

    state_t                  state;
    logic [NB_IF_ID-1:0]     shadow_if_id;
    logic [NB_ID_EX-1:0]     shadow_id_ex;
    logic [NB_EX_MEM-1:0]    shadow_ex_mem;
    logic [NB_MEM_WB-1:0]    shadow_mem_wb;
    logic [NB_CONTROL-1:0]   shadow_control;
    logic [4:0]              mask_q;
    logic [2:0]              scan_idx;
    logic [CNT_W-1:0]        byte_cnt;
    logic [NB_MAX-1:0]       payload;

    logic                    found;
    logic [2:0]              found_idx;
    logic [NB_MAX-1:0]       sel_payload;
    logic [CNT_W-1:0]        sel_cnt;

    // Lowest enabled frame at or above the scan index; scan_idx may reach 5 = exhausted.
    always_comb begin
        found     = 1'b0;
        found_idx = 3'd0;
        for (int i = 4; i >= 0; i--) begin
            if (mask_q[i] && (3'(i) >= scan_idx)) begin
                found     = 1'b1;
                found_idx = 3'(i);
            end
        end
    end

    // Payload is left-aligned so the next byte is always the top slice of the shifter.
    always_comb begin
        sel_payload = '0;
        sel_cnt     = '0;
        case (found_idx)
            3'd0: begin
                sel_payload = NB_MAX'(shadow_if_id) << (NB_MAX - NB_IF_ID);
                sel_cnt     = CNT_W'(NB_IF_ID / NB_DATA);
            end
            3'd1: begin
                sel_payload = NB_MAX'(shadow_id_ex) << (NB_MAX - NB_ID_EX);
                sel_cnt     = CNT_W'(NB_ID_EX / NB_DATA);
            end
            3'd2: begin
                sel_payload = NB_MAX'(shadow_ex_mem) << (NB_MAX - NB_EX_MEM);
                sel_cnt     = CNT_W'(NB_EX_MEM / NB_DATA);
            end
            3'd3: begin
                sel_payload = NB_MAX'(shadow_mem_wb) << (NB_MAX - NB_MEM_WB);
                sel_cnt     = CNT_W'(NB_MEM_WB / NB_DATA);
            end
            default: begin
                sel_payload = NB_MAX'(shadow_control) << (NB_MAX - NB_CONTROL);
                sel_cnt     = CNT_W'(NB_CONTROL / NB_DATA);
            end
        endcase
    end

    always_ff @(posedge clk or negedge i_rst_n) begin
        if (!i_rst_n) begin
            state          <= IDLE;
            shadow_if_id   <= '0;
            shadow_id_ex   <= '0;
            shadow_ex_mem  <= '0;
            shadow_mem_wb  <= '0;
            shadow_control <= '0;
            mask_q         <= '0;
            scan_idx       <= '0;
            byte_cnt       <= '0;
            payload        <= '0;
            o_tx_start     <= 1'b0;
            o_data         <= '0;
            o_busy         <= 1'b0;
            o_frame_idx    <= '0;
            o_dump_done    <= 1'b0;
            o_aborted      <= 1'b0;
        end else begin
            o_tx_start  <= 1'b0;
            o_dump_done <= 1'b0;
            o_aborted   <= 1'b0;
            if (state != IDLE && i_abort) begin
                // Abort takes priority over txDone; an in-flight byte simply finishes on the line.
                state     <= IDLE;
                o_busy    <= 1'b0;
                o_aborted <= 1'b1;
            end else begin
                case (state)
                    IDLE: begin
                        if (i_dump_start) begin
                            shadow_if_id   <= i_data_IF_ID;
                            shadow_id_ex   <= i_data_ID_EX;
                            shadow_ex_mem  <= i_data_EX_MEM;
                            shadow_mem_wb  <= i_data_MEM_WB;
                            shadow_control <= i_data_CONTROL;
                            mask_q         <= i_frame_mask;
                            scan_idx       <= '0;
                            o_frame_idx    <= '0;
                            o_busy         <= 1'b1;
                            state          <= SELECT;
                        end
                    end
                    SELECT: begin
                        if (found) begin
                            o_frame_idx <= found_idx;
                            o_data      <= HDR_BASE | NB_DATA'(found_idx);
                            byte_cnt    <= sel_cnt;
                            payload     <= sel_payload;
                            o_tx_start  <= 1'b1;
                            state       <= SEND;
                        end else begin
                            o_dump_done <= 1'b1;
                            state       <= DONE;
                        end
                    end
                    SEND: begin
                        state <= WAIT;
                    end
                    WAIT: begin
                        if (i_txDone) begin
                            if (byte_cnt != '0) begin
                                o_data     <= payload[NB_MAX-1 -: NB_DATA];
                                payload    <= payload << NB_DATA;
                                byte_cnt   <= byte_cnt - 1'b1;
                                o_tx_start <= 1'b1;
                                state      <= SEND;
                            end else begin
                                scan_idx <= o_frame_idx + 3'd1;
                                state    <= SELECT;
                            end
                        end
                    end
                    DONE: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                    default: begin
                        o_busy <= 1'b0;
                        state  <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule
